cla_pipe_addsub: RTL and testbench
==================================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the ToyALU datapath. It generalises the fixed 32-bit combinational CLA to any `WIDTH`, split into `SEGS` registered carry segments. It adds an add/subtract mode, a carry-in, and a valid/ready handshake with backpressure. Results leave in order after a fixed latency, and optional status flags come out alongside them.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Must be a multiple of `4*SEGS`.
- `SEGS`, default 2: number of pipeline segments. Valid range 1..8. Latency equals `SEGS` cycles.

Ports:
- `clk`, input, 1: single clock. All registers update on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operand beat offered.
- `in_ready`, output, 1: pipeline can accept a beat this cycle.
- `in_a`, input, `WIDTH`: operand A.
- `in_b`, input, `WIDTH`: operand B.
- `in_op`, input, 1: operation select, 0 = ADD, 1 = SUB.
- `in_cin`, input, 1: carry-in for ADD, borrow-in for SUB.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, `WIDTH`: result.
- `out_cout`, output, 1: carry-out. For SUB, 1 means no borrow.
- `out_ovf`, output, 1: signed overflow. Present only with `CLA_PIPE_FLAGS_EN`.
- `out_zero`, output, 1: `out_sum` is zero. Present only with `CLA_PIPE_FLAGS_EN`.

## Operation
- ADD computes A + B + cin.
- SUB computes A + ~B + !cin, which equals A − B − cin. The inversion is applied at the input stage.
- Segment width is `SW = WIDTH/SEGS`. Stage k adds bits [k*SW +: SW] using 4-bit lookahead groups. The carry into stage k comes from the stage k−1 register.
- Stage k register contents:
  - valid bit;
  - low sum bits computed so far;
  - remaining upper A and (possibly inverted) B bits;
  - segment carry;
  - the carry into the MSB, in the last stage only.
- Stage 0 registers the result of segment 0 directly from the inputs. The output register is the stage `SEGS`−1 register.
- Advance condition: `adv = !out_valid || out_ready`. All stages shift together when `adv` is high; otherwise every stage holds.
- `in_ready = adv`. A beat is accepted when `in_valid && in_ready`. On an advance with no accepted beat, a bubble (valid = 0) enters stage 0.
- Bubbles are not collapsed. Throughput is 1 result per cycle when there is no backpressure.
- Flags:
  - `out_ovf` = (carry into MSB) XOR `out_cout`.
  - `out_zero` = NOR of `out_sum`.
  - Both are registered together with the sum in the last stage.
- Width rule: `out_sum` is exactly `WIDTH` bits, and the carry beyond it appears only on `out_cout`.

## Timing
- Reset: all valid bits are 0. `out_sum`, `out_cout`, `out_ovf` and `out_zero` are 0. `in_ready` is 1 once reset is deasserted.
- Latency: a beat accepted at edge N is presented at `out_valid` after edge N+`SEGS`−1. With `SEGS`=1, the output is registered one cycle after acceptance.
- While `out_valid && !out_ready`:
  - all outputs are held stable;
  - `in_ready` is 0;
  - inputs are ignored.
- Accept and retire in the same cycle is legal. When both happen, the pipeline shifts once.
- Reset asserted mid-operation: all in-flight beats are discarded immediately (asynchronously), and the outputs go to their reset values.
- Outputs other than `out_valid` are don't-care while `out_valid` = 0. The bench checks them only when valid.

## Configuration
- Macro: `CLA_PIPE_FLAGS_EN`.
- Defined: the `out_ovf` and `out_zero` ports and their pipeline registers exist and follow the rules in Operation.
- Undefined: those ports and registers are removed. Sum, carry and handshake behaviour are unchanged.

## Structure
- Package `cla_pipe_pkg` holds:
  - `op_e` typedef with `OP_ADD` = 0 and `OP_SUB` = 1;
  - the constant `CLA_GROUP` = 4;
  - a parameter-check function that validates `WIDTH` % (4*`SEGS`) == 0.
- Sub-module `cla_seg`, combinational, parameter `SW`:
  - inputs: a, b, cin;
  - outputs: sum, cout, c_msb;
  - internally chains `SW/4` 4-bit lookahead groups.
- The top module instantiates one `cla_seg` per stage. It also owns the stage registers and the handshake logic.

## Test plan
- ADD with `WIDTH`=32, `SEGS`=2: 0xFFFFFFFF + 0x00000001, cin = 0. Exactly 2 cycles later: sum 0x00000000, cout 1, zero 1, ovf 0.
- SUB: 5 − 7, cin = 0. Result: sum 0xFFFFFFFE, cout 0, ovf 0, zero 0. Also SUB 0x80000000 − 1: sum 0x7FFFFFFF, ovf 1, cout 1.
- ADD 0x7FFFFFFF + 0x00000001: sum 0x80000000, ovf 1, cout 0. Also ADD 3 + 4 with cin = 1: sum 8.
- Backpressure: send 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) while `out_ready` is held 0 for 5 cycles. Required: outputs stable at sum 2, `in_ready` 0, then 2, 4, 6, 8 in order with no loss or duplication after release.
- Reset pulse with 2 beats in flight. Required: `out_valid` drops immediately, and no stale result appears after reset deassertion.
- `WIDTH`=16, `SEGS`=4: 0x0FFF + 0x0001 gives sum 0x1000 with latency 4, exercising carry across segment boundaries. Run with and without `CLA_PIPE_FLAGS_EN`; sum and cout must be identical in both builds.

Source files
------------

// File: rtl/cla_pipe_pkg.sv
// Shared types, constants and parameter checking for the pipelined CLA adder/subtractor.
package cla_pipe_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int CLA_GROUP = 4;

    // Every segment must hold a whole number of lookahead groups.
    function automatic bit cla_params_ok(input int width, input int segs);
        return (segs >= 1) && (segs <= 8) && (width > 0) &&
               ((width % (CLA_GROUP * segs)) == 0);
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SW-bit carry-lookahead segment built from 4-bit lookahead groups
// rippling group carries; also exposes the carry into its MSB for overflow detection.
module cla_seg
    import cla_pipe_pkg::*;
#(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    localparam int NG = SW / CLA_GROUP;

    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [SW:0]   carry;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        logic       c;
        logic [3:0] gp;
        logic [3:0] gg;
        carry    = '0;
        c        = cin;
        gp       = '0;
        gg       = '0;
        carry[0] = cin;
        for (int i = 0; i < NG; i++) begin
            gp = p[i*CLA_GROUP +: CLA_GROUP];
            gg = g[i*CLA_GROUP +: CLA_GROUP];
            carry[i*CLA_GROUP+1] = gg[0] | (gp[0] & c);
            carry[i*CLA_GROUP+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c);
            carry[i*CLA_GROUP+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
                                   (gp[2] & gp[1] & gp[0] & c);
            // Group generate/propagate gives the carry out of the whole group in one level.
            c = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
                (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & c);
            carry[i*CLA_GROUP+4] = c;
        end
    end

    assign sum   = p ^ carry[SW-1:0];
    assign cout  = carry[SW];
    assign c_msb = carry[SW-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: SEGS registered segments, valid/ready handshake.
// Define CLA_PIPE_FLAGS_EN to add registered signed-overflow (out_ovf) and zero (out_zero) flags.
module cla_pipe_addsub
    import cla_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEGS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero
`endif
);

    localparam int SW = WIDTH / SEGS;
    localparam bit PARAMS_OK = cla_params_ok(WIDTH, SEGS);
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SW{1'b1}});

    if (!PARAMS_OK) begin : g_param_check
        $error("cla_pipe_addsub: WIDTH must be a multiple of 4*SEGS and SEGS in 1..8");
    end

    op_e              op;
    logic             adv;
    logic [SEGS-1:0]  vld_q;
    logic [SEGS-1:0]  c_q;
    logic [WIDTH-1:0] a_q   [SEGS];
    logic [WIDTH-1:0] b_q   [SEGS];
    logic [WIDTH-1:0] sum_q [SEGS];

    logic [SEGS-1:0]  vld_in;
    logic [SEGS-1:0]  c_in;
    logic [SEGS-1:0]  c_nx;
    logic             msb_nx [SEGS];
    logic [WIDTH-1:0] a_in   [SEGS];
    logic [WIDTH-1:0] b_in   [SEGS];
    logic [WIDTH-1:0] sum_in [SEGS];
    logic [WIDTH-1:0] sum_nx [SEGS];

    assign op       = op_e'(in_op);
    assign adv      = !vld_q[SEGS-1] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        logic [SW-1:0] seg_sum;

        if (k == 0) begin : g_first
            // Subtraction is folded in here: A + ~B + !borrow.
            assign vld_in[0] = in_valid;
            assign a_in[0]   = in_a;
            assign b_in[0]   = (op == OP_SUB) ? ~in_b : in_b;
            assign c_in[0]   = (op == OP_SUB) ? ~in_cin : in_cin;
            assign sum_in[0] = '0;
        end else begin : g_rest
            assign vld_in[k] = vld_q[k-1];
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign sum_in[k] = sum_q[k-1];
        end

        cla_seg #(.SW(SW)) u_seg (
            .a     (a_in[k][k*SW +: SW]),
            .b     (b_in[k][k*SW +: SW]),
            .cin   (c_in[k]),
            .sum   (seg_sum),
            .cout  (c_nx[k]),
            .c_msb (msb_nx[k])
        );

        assign sum_nx[k] = (sum_in[k] & ~(SEG_MASK << (k*SW))) |
                           (WIDTH'(seg_sum) << (k*SW));
    end

    // All stages shift together on adv; a rejected slot enters as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < SEGS; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_in;
            c_q   <= c_nx;
            for (int k = 0; k < SEGS; k++) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                sum_q[k] <= sum_nx[k];
            end
        end
    end

    assign out_valid = vld_q[SEGS-1];
    assign out_sum   = sum_q[SEGS-1];
    assign out_cout  = c_q[SEGS-1];

`ifdef CLA_PIPE_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            ovf_q  <= msb_nx[SEGS-1] ^ c_nx[SEGS-1];
            zero_q <= ~|sum_nx[SEGS-1];
        end
    end

    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
`else
    logic unused_msb;
    assign unused_msb = msb_nx[SEGS-1];
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub: a 32-bit/2-segment and a 16-bit/4-segment instance.
// Flag checks are compiled in only when CLA_PIPE_FLAGS_EN is defined.
module tb_cla_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        v32, r32, op32, cin32, ov32, or32, co32;
    logic [31:0] a32, b32, s32;
    logic        v16, r16, op16, cin16, ov16, or16, co16;
    logic [15:0] a16, b16, s16;
`ifdef CLA_PIPE_FLAGS_EN
    logic        ovf32, z32, ovf16, z16;
`endif

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(32), .SEGS(2)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v32),
        .in_ready  (r32),
        .in_a      (a32),
        .in_b      (b32),
        .in_op     (op32),
        .in_cin    (cin32),
        .out_valid (ov32),
        .out_ready (or32),
        .out_sum   (s32),
        .out_cout  (co32)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .out_ovf   (ovf32),
        .out_zero  (z32)
`endif
    );

    cla_pipe_addsub #(.WIDTH(16), .SEGS(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v16),
        .in_ready  (r16),
        .in_a      (a16),
        .in_b      (b16),
        .in_op     (op16),
        .in_cin    (cin16),
        .out_valid (ov16),
        .out_ready (or16),
        .out_sum   (s16),
        .out_cout  (co16)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .out_ovf   (ovf16),
        .out_zero  (z16)
`endif
    );

    // Drives one beat into the 32-bit instance and reports what comes out and after how many edges.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic cin, output logic [31:0] sum, output logic cout,
                         output logic ovf, output logic zero, output int lat);
        or32 = 1'b1;
        @(negedge clk);
        a32 = a; b32 = b; op32 = op; cin32 = cin; v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
        lat = -1; sum = '0; cout = 1'b0; ovf = 1'b0; zero = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (ov32) begin
                lat = i; sum = s32; cout = co32;
`ifdef CLA_PIPE_FLAGS_EN
                ovf = ovf32; zero = z32;
`endif
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic op,
                         input logic cin, output logic [15:0] sum, output logic cout,
                         output int lat);
        or16 = 1'b1;
        @(negedge clk);
        a16 = a; b16 = b; op16 = op; cin16 = cin; v16 = 1'b1;
        @(negedge clk);
        v16 = 1'b0;
        lat = -1; sum = '0; cout = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (ov16) begin
                lat = i; sum = s16; cout = co16;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v32 = 0; a32 = '0; b32 = '0; op32 = 0; cin32 = 0; or32 = 1;
        v16 = 0; a16 = '0; b16 = '0; op16 = 0; cin16 = 0; or16 = 1;
        repeat (3) @(negedge clk);
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset.valid32 got %b want 0", ov32); end
        checks++; if (s32 !== 32'h0) begin errors++; $display("FAIL reset.sum32 got %h want 0", s32); end
        checks++; if (co32 !== 1'b0) begin errors++; $display("FAIL reset.cout32 got %b want 0", co32); end
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset.valid16 got %b want 0", ov16); end
`ifdef CLA_PIPE_FLAGS_EN
        checks++; if ({ovf32, z32} !== 2'b00) begin errors++; $display("FAIL reset.flags32 got %b want 00", {ovf32, z32}); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (r32 !== 1'b1) begin errors++; $display("FAIL reset.in_ready32 got %b want 1", r32); end
        checks++; if (r16 !== 1'b1) begin errors++; $display("FAIL reset.in_ready16 got %b want 1", r16); end
    endtask

    task automatic test_add();
        logic [31:0] sum; logic cout, ovf, zero; int lat;
        run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, sum, cout, ovf, zero, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_wrap.latency got %0d want 2", lat); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL add_wrap.sum got %h want 00000000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL add_wrap.cout got %b want 1", cout); end
`ifdef CLA_PIPE_FLAGS_EN
        checks++; if ({ovf, zero} !== 2'b01) begin errors++; $display("FAIL add_wrap.flags got ovf/zero %b want 01", {ovf, zero}); end
`endif
        run32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, sum, cout, ovf, zero, lat);
        checks++; if (sum !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf.sum got %h want 80000000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_ovf.cout got %b want 0", cout); end
`ifdef CLA_PIPE_FLAGS_EN
        checks++; if ({ovf, zero} !== 2'b10) begin errors++; $display("FAIL add_ovf.flags got ovf/zero %b want 10", {ovf, zero}); end
`endif
        run32(32'd3, 32'd4, 1'b0, 1'b1, sum, cout, ovf, zero, lat);
        checks++; if (sum !== 32'd8) begin errors++; $display("FAIL add_cin.sum got %h want 00000008", sum); end
        run32(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, sum, cout, ovf, zero, lat);
        checks++; if ({cout, sum} !== {1'b0, 32'h0001_0000}) begin errors++; $display("FAIL add_segcarry got %b_%h want 0_00010000", cout, sum); end
    endtask

    task automatic test_sub();
        logic [31:0] sum; logic cout, ovf, zero; int lat;
        run32(32'd5, 32'd7, 1'b1, 1'b0, sum, cout, ovf, zero, lat);
        checks++; if (sum !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_neg.sum got %h want fffffffe", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_neg.cout got %b want 0", cout); end
`ifdef CLA_PIPE_FLAGS_EN
        checks++; if ({ovf, zero} !== 2'b00) begin errors++; $display("FAIL sub_neg.flags got ovf/zero %b want 00", {ovf, zero}); end
`endif
        run32(32'h8000_0000, 32'd1, 1'b1, 1'b0, sum, cout, ovf, zero, lat);
        checks++; if (sum !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_ovf.sum got %h want 7fffffff", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub_ovf.cout got %b want 1", cout); end
`ifdef CLA_PIPE_FLAGS_EN
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf.ovf got %b want 1", ovf); end
`endif
        run32(32'd10, 32'd3, 1'b1, 1'b1, sum, cout, ovf, zero, lat);
        checks++; if ({cout, sum} !== {1'b1, 32'd6}) begin errors++; $display("FAIL sub_borrow got %b_%h want 1_00000006", cout, sum); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ret [4];
        int got, idx;
        got = 0; idx = 0;
        for (int i = 0; i < 4; i++) ret[i] = '0;
        or32 = 1'b1;
        repeat (3) @(negedge clk);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc != 0) @(negedge clk);
            or32 = (cyc >= 7);
            if (idx < 4) begin
                v32 = 1'b1; a32 = 32'(idx + 1); b32 = 32'(idx + 1); op32 = 1'b0; cin32 = 1'b0;
            end else begin
                v32 = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc < 7) begin
                checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL bp.hold_valid cyc %0d got %b want 1", cyc, ov32); end
                checks++; if (s32 !== 32'd2) begin errors++; $display("FAIL bp.hold_sum cyc %0d got %h want 00000002", cyc, s32); end
                checks++; if (r32 !== 1'b0) begin errors++; $display("FAIL bp.in_ready cyc %0d got %b want 0", cyc, r32); end
            end
            if (ov32 && or32) begin
                if (got < 4) ret[got] = s32;
                got++;
            end
            if (v32 && r32) idx++;
            if (got >= 4 && idx >= 4) break;
        end
        v32 = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL bp.count got %0d want 4", got); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ret[i] !== 32'(2 * (i + 1))) begin errors++; $display("FAIL bp.order[%0d] got %h want %h", i, ret[i], 32'(2 * (i + 1))); end
        end
        @(negedge clk);
        #1;
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL bp.no_dup got valid %b want 0", ov32); end
    endtask

    task automatic test_reset_mid();
        int stale;
        or32 = 1'b1;
        repeat (3) @(negedge clk);
        v32 = 1'b1; a32 = 32'd1; b32 = 32'd1; op32 = 1'b0; cin32 = 1'b0;
        @(negedge clk);
        a32 = 32'd2; b32 = 32'd2;
        @(negedge clk);
        v32 = 1'b0;
        checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL rst_mid.inflight got valid %b want 1", ov32); end
        rst_n = 1'b0;
        #1;
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rst_mid.valid_drop got %b want 0", ov32); end
        checks++; if ({co32, s32} !== 33'h0) begin errors++; $display("FAIL rst_mid.outputs got %b_%h want 0_00000000", co32, s32); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov32) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rst_mid.stale got %0d valid cycles want 0", stale); end
    endtask

    task automatic test_seg4();
        logic [15:0] sum; logic cout; int lat;
        run16(16'h0FFF, 16'h0001, 1'b0, 1'b0, sum, cout, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL seg4.latency got %0d want 4", lat); end
        checks++; if ({cout, sum} !== {1'b0, 16'h1000}) begin errors++; $display("FAIL seg4.carry_chain got %b_%h want 0_1000", cout, sum); end
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, sum, cout, lat);
        checks++; if ({cout, sum} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL seg4.wrap got %b_%h want 1_0000", cout, sum); end
        run16(16'h0000, 16'h0001, 1'b1, 1'b0, sum, cout, lat);
        checks++; if ({cout, sum} !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL seg4.sub_borrow got %b_%h want 0_ffff", cout, sum); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_seg4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
